// File: rtl/nla_pkg.sv
// Shared types and constants for the nonlinear-approximation sequencer:
// controller state encoding, FP32 field positions, SELU scale constants, adder mode codes.
package nla_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLR    = 4'd1,
        ST_COEF   = 4'd2,
        ST_SIG    = 4'd3,
        ST_RAW    = 4'd4,
        ST_FINAL  = 4'd5,
        ST_DIRECT = 4'd6,
        ST_RESULT = 4'd7,
        ST_DONE   = 4'd8
    } nla_state_e;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;

    // Scale constants consumed by the datapath ROM: lambda and lambda*alpha.
    localparam logic [31:0] NLA_LAMBDA       = 32'h3F86_7D5F;
    localparam logic [31:0] NLA_LAMBDA_ALPHA = 32'h3FE1_0966;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // An all-zero exponent field marks +/-0 and denormals.
    function automatic logic is_zero_exp(input logic [FP_EXP_MSB-FP_EXP_LSB:0] exp_field);
        return (exp_field == 8'd0);
    endfunction

endpackage

// File: rtl/nla_step_timer.sv
// Per-state dwell timer: restarts on every state change and flags the first
// and last cycle of a STEP_CYCLES-long step.
module nla_step_timer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic step_first,
    output logic step_last
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          first_r;

    // Dwell counter: saturates at the last cycle so long waits cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            first_r <= 1'b0;
        end else if (restart) begin
            cnt_r   <= {CW{1'b0}};
            first_r <= 1'b1;
        end else begin
            first_r <= 1'b0;
            if (cnt_r != LAST_CNT) begin
                cnt_r <= cnt_r + ONE_CNT;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign step_first = first_r;
    assign step_last  = (cnt_r == LAST_CNT);

endmodule

// File: rtl/nla_seq_ctrl.sv
// Sequencer for the FP32 SELU-style approximation datapath: operand capture, strobe
// sequencing and coefficient addressing. Optional macro NLA_ZERO_BYPASS_EN routes +/-0 and denormals to DIRECT.
module nla_seq_ctrl
    import nla_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEGREE      = 4,
    parameter int               STEP_CYCLES = 1,
    parameter logic [DEGREE:0]  SUB_MASK    = {(DEGREE+1){1'b0}}
) (
    input  logic                         clk_n,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic [WIDTH-1:0]             signal,
    output logic [$clog2(DEGREE+1)-1:0]  coeff_addr,
    output logic                         mode,
    output logic                         dp_rst_n,
    output logic                         LD_coeff,
    output logic                         LD_signal,
    output logic                         LD_direct,
    output logic                         LD_rawResult,
    output logic                         LD_final,
    output logic                         LD_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int KW = $clog2(DEGREE+1);
    localparam logic [KW-1:0] K_TOP  = KW'(DEGREE);
    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    nla_state_e    state_r;
    nla_state_e    state_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_s;
    logic          accept_s;
    logic          take_direct_s;
    logic          restart_s;
    logic          step_first_s;
    logic          step_last_s;

    assign accept_s  = in_valid && (state_r == ST_IDLE);
    assign restart_s = (state_s != state_r);

`ifdef NLA_ZERO_BYPASS_EN
    assign take_direct_s = !in_data[WIDTH-1] || is_zero_exp(in_data[FP_EXP_MSB:FP_EXP_LSB]);
`else
    assign take_direct_s = !in_data[WIDTH-1];
`endif

    nla_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk        (clk_n),
        .rst        (rst_n),
        .restart    (restart_s),
        .step_first (step_first_s),
        .step_last  (step_last_s)
    );

    // Next-state and coefficient-index selection.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = take_direct_s ? ST_DIRECT : ST_CLR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_s = ST_COEF;
                k_s     = K_TOP;
            end
            ST_COEF: begin
                if (step_last_s) begin
                    state_s = ST_SIG;
                end else begin
                    state_s = ST_COEF;
                end
            end
            ST_SIG: begin
                // Index stops at zero; leaving the loop is the only way past c_0.
                if (step_last_s) begin
                    if (k_r == K_ZERO) begin
                        state_s = ST_RAW;
                    end else begin
                        state_s = ST_COEF;
                        k_s     = k_r - K_ONE;
                    end
                end else begin
                    state_s = ST_SIG;
                end
            end
            ST_RAW: begin
                if (step_last_s) begin
                    state_s = ST_FINAL;
                end else begin
                    state_s = ST_RAW;
                end
            end
            ST_FINAL: begin
                if (step_last_s) begin
                    state_s = ST_RESULT;
                end else begin
                    state_s = ST_FINAL;
                end
            end
            ST_DIRECT: begin
                if (step_last_s) begin
                    state_s = ST_RESULT;
                end else begin
                    state_s = ST_DIRECT;
                end
            end
            ST_RESULT: begin
                if (step_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RESULT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = K_ZERO;
            end
        endcase
    end

    // State, step index and handshake/status outputs, registered from the next state.
    always_ff @(posedge clk_n) begin
        if (rst_n) begin
            state_r   <= ST_IDLE;
            k_r       <= K_ZERO;
            dp_rst_n  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_r   <= state_s;
            k_r       <= k_s;
            dp_rst_n  <= (state_s != ST_CLR);
            out_valid <= (state_s == ST_DONE);
            busy      <= (state_s != ST_IDLE);
            in_ready  <= (state_s == ST_IDLE);
        end
    end

    // Operand hold register and coefficient address/mode, loaded on COEF entry and held between.
    always_ff @(posedge clk_n) begin
        if (rst_n) begin
            signal     <= {WIDTH{1'b0}};
            coeff_addr <= K_ZERO;
            mode       <= MODE_ADD;
        end else begin
            if (accept_s) begin
                signal <= in_data;
            end else begin
                signal <= signal;
            end
            if ((state_s == ST_COEF) && (state_r != ST_COEF)) begin
                coeff_addr <= k_s;
                mode       <= SUB_MASK[k_s] ? MODE_SUB : MODE_ADD;
            end else begin
                coeff_addr <= coeff_addr;
                mode       <= mode;
            end
        end
    end

    // Strobes are decoded from flops only: one cycle at the start of each step.
    assign LD_coeff     = step_first_s && (state_r == ST_COEF);
    assign LD_signal    = step_first_s && (state_r == ST_SIG);
    assign LD_direct    = step_first_s && (state_r == ST_DIRECT);
    assign LD_rawResult = step_first_s && (state_r == ST_RAW);
    assign LD_final     = step_first_s && (state_r == ST_FINAL);
    assign LD_result    = step_first_s && (state_r == ST_RESULT);

endmodule

// File: tb/tb_nla_seq_ctrl.sv
// Self-checking bench for nla_seq_ctrl: two instances (STEP_CYCLES 1 and 3) checked
// cycle by cycle against a step-list model built from the operation description.
module tb_nla_seq_ctrl;

    localparam int         D     = 4;
    localparam logic [D:0] MASK1 = 5'b10110;
    localparam logic [D:0] MASK3 = 5'b01001;

    localparam logic [5:0] LD_NONE = 6'b000000;
    localparam logic [5:0] LD_C    = 6'b100000;
    localparam logic [5:0] LD_S    = 6'b010000;
    localparam logic [5:0] LD_D    = 6'b001000;
    localparam logic [5:0] LD_R    = 6'b000100;
    localparam logic [5:0] LD_F    = 6'b000010;
    localparam logic [5:0] LD_E    = 6'b000001;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]        in_valid;
    logic [1:0]        out_ready;
    logic [1:0][31:0]  in_data;
    wire  [1:0]        in_ready;
    wire  [1:0]        mode;
    wire  [1:0]        dp_rst_n;
    wire  [1:0]        out_valid;
    wire  [1:0]        busy;
    wire  [1:0][31:0]  signal;
    wire  [1:0][2:0]   coeff_addr;
    wire  [1:0][5:0]   ld;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_q[$];
    logic [2:0]  m_addr [2];
    logic        m_mode [2];

    always #5 clk = ~clk;

    nla_seq_ctrl #(.WIDTH(32), .DEGREE(D), .STEP_CYCLES(1), .SUB_MASK(MASK1)) u_s1 (
        .clk_n(clk), .rst_n(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .signal(signal[0]), .coeff_addr(coeff_addr[0]), .mode(mode[0]),
        .dp_rst_n(dp_rst_n[0]), .LD_coeff(ld[0][5]), .LD_signal(ld[0][4]), .LD_direct(ld[0][3]),
        .LD_rawResult(ld[0][2]), .LD_final(ld[0][1]), .LD_result(ld[0][0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
    );

    nla_seq_ctrl #(.WIDTH(32), .DEGREE(D), .STEP_CYCLES(3), .SUB_MASK(MASK3)) u_s3 (
        .clk_n(clk), .rst_n(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .signal(signal[1]), .coeff_addr(coeff_addr[1]), .mode(mode[1]),
        .dp_rst_n(dp_rst_n[1]), .LD_coeff(ld[1][5]), .LD_signal(ld[1][4]), .LD_direct(ld[1][3]),
        .LD_rawResult(ld[1][2]), .LD_final(ld[1][1]), .LD_result(ld[1][0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
    );

    function automatic logic [13:0] pk(input logic [5:0] l, input logic dp, input logic [2:0] a,
                                       input logic md, input logic bz, input logic ov, input logic ir);
        return {l, dp, a, md, bz, ov, ir};
    endfunction

    function automatic logic [13:0] obs(input int sel);
        return pk(ld[sel], dp_rst_n[sel], coeff_addr[sel], mode[sel], busy[sel], out_valid[sel], in_ready[sel]);
    endfunction

    function automatic int step_of(input int sel);
        return (sel == 0) ? 1 : 3;
    endfunction

    function automatic logic [D:0] mask_of(input int sel);
        return (sel == 0) ? MASK1 : MASK3;
    endfunction

    function automatic bit goes_direct(input logic [31:0] x);
`ifdef NLA_ZERO_BYPASS_EN
        return (x[31] == 1'b0) || (x[30:23] == 8'd0);
`else
        return (x[31] == 1'b0);
`endif
    endfunction

    function automatic int spec_latency(input int sel, input logic [31:0] x);
        return goes_direct(x) ? 2 * step_of(sel) : 1 + step_of(sel) * (2 * D + 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic add_step(input int sel, input logic [5:0] l);
        for (int c = 0; c < step_of(sel); c++)
            exp_q.push_back(pk((c == 0) ? l : LD_NONE, 1'b1, m_addr[sel], m_mode[sel], 1'b1, 1'b0, 1'b0));
    endtask

    // Expected busy-phase trace of one operation, one entry per cycle after acceptance.
    task automatic model_op(input int sel, input logic [31:0] x);
        logic [D:0] msk;
        msk = mask_of(sel);
        exp_q.delete();
        if (goes_direct(x)) begin
            add_step(sel, LD_D);
            add_step(sel, LD_E);
        end else begin
            exp_q.push_back(pk(LD_NONE, 1'b0, m_addr[sel], m_mode[sel], 1'b1, 1'b0, 1'b0));
            for (int k = D; k >= 0; k--) begin
                m_addr[sel] = 3'(k);
                m_mode[sel] = msk[k];
                add_step(sel, LD_C);
                add_step(sel, LD_S);
            end
            add_step(sel, LD_R);
            add_step(sel, LD_F);
            add_step(sel, LD_E);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_addr[s] = 3'd0;
            m_mode[s] = 1'b0;
        end
    endtask

    // One operation from offer to return to IDLE; abort_at >= 0 pulses reset at that trace cycle.
    task automatic run_op(input int sel, input logic [31:0] x, input int hold, input bit noisy,
                          input int abort_at, output int lat);
        logic [13:0] done_v;
        chk("idle_ready", {31'd0, in_ready[sel]}, 32'd1);
        in_valid[sel]  = 1'b1;
        in_data[sel]   = x;
        out_ready[sel] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[sel] = 1'b0;
        lat = -1;
        model_op(sel, x);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (lat < 0 && out_valid[sel]) lat = i;
            chk($sformatf("trace%0d[%0d]", sel, i), {18'd0, obs(sel)}, {18'd0, exp_q[i]});
            chk("signal_hold", signal[sel], x);
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                model_reset();
                chk("abort_state", {18'd0, obs(sel)}, {18'd0, pk(LD_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)});
                chk("abort_signal", signal[sel], 32'd0);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_idle", {18'd0, obs(sel)}, {18'd0, pk(LD_NONE, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)});
                return;
            end
            if (noisy) begin
                in_valid[sel]  = 1'($urandom_range(0, 1));
                in_data[sel]   = $urandom;
                out_ready[sel] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        if (lat < 0 && out_valid[sel]) lat = exp_q.size();
        out_ready[sel] = 1'b0;
        if (noisy) begin
            in_valid[sel] = 1'b1;
            in_data[sel]  = ~x;
        end
        done_v = pk(LD_NONE, 1'b1, m_addr[sel], m_mode[sel], 1'b1, 1'b1, 1'b0);
        for (int h = 0; h < hold; h++) begin
            chk("done_hold", {18'd0, obs(sel)}, {18'd0, done_v});
            @(negedge clk);
        end
        out_ready[sel] = 1'b1;
        in_valid[sel]  = 1'b0;
        chk("done_hs", {18'd0, obs(sel)}, {18'd0, done_v});
        @(negedge clk);
        out_ready[sel] = 1'b0;
        chk("back_idle", {18'd0, obs(sel)}, {18'd0, pk(LD_NONE, 1'b1, m_addr[sel], m_mode[sel], 1'b0, 1'b0, 1'b1)});
        chk("signal_kept", signal[sel], x);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int sel;
        logic [31:0] x;
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        in_data   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_state", {18'd0, obs(s)}, {18'd0, pk(LD_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)});
            chk("reset_signal", signal[s], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++)
            chk("post_reset", {18'd0, obs(s)}, {18'd0, pk(LD_NONE, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)});

        run_op(0, 32'h4000_0000, 0, 1'b0, -1, lat);
        chk("lat_pos_s1", lat, 32'd2);
        run_op(0, 32'hBF80_0000, 1, 1'b0, -1, lat);
        chk("lat_neg_s1", lat, 32'd14);
        run_op(1, 32'hBF80_0000, 0, 1'b0, -1, lat);
        chk("lat_neg_s3", lat, 32'd40);
        run_op(1, 32'h3F00_0000, 2, 1'b0, -1, lat);
        chk("lat_pos_s3", lat, 32'd6);
        run_op(0, 32'hC000_0000, 5, 1'b1, -1, lat);
        chk("lat_hold", lat, 32'd14);
        run_op(0, 32'h8000_0000, 0, 1'b0, -1, lat);
`ifdef NLA_ZERO_BYPASS_EN
        chk("lat_negzero", lat, 32'd2);
`else
        chk("lat_negzero", lat, 32'd14);
`endif
        run_op(0, 32'h8040_0000, 0, 1'b0, -1, lat);
        chk("lat_denorm", lat, 32'(spec_latency(0, 32'h8040_0000)));

        run_op(0, 32'hC040_0000, 0, 1'b0, 6, lat);
        run_op(0, 32'hBF80_0000, 0, 1'b0, -1, lat);
        chk("lat_after_abort", lat, 32'd14);

        for (int it = 0; it < 12; it++) begin
            sel = $urandom_range(0, 1);
            x   = $urandom;
            if (it < 3) x[30:23] = 8'd0;
            run_op(sel, x, $urandom_range(0, 3), 1'b1, -1, lat);
            chk("lat_rand", lat, 32'(spec_latency(sel, x)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
